// File: rtl/sme_pkg.sv
// Shared types and default sizing for the SME operand gather block.
package sme_pkg;

  localparam int SME_XLEN_DEFAULT = 32;
  localparam int SME_SMAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LAST  = 2'd2,
    ST_ISSUE = 2'd3
  } gather_state_e;

endpackage

// File: rtl/sme_operand_gather.sv
// Gathers d masked shares of rs1/rs2 from the share register file and presents them to the ALU.
// Optional: define SME_GATHER_CLEAR_EN to zero all slots after each ALU handshake or flush.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// req_valid/req_ready accept a request; alu_valid/alu_ready hand the operands off.
// alu_valid, once high, holds with stable operands until alu_ready; flush overrides both.
module sme_operand_gather
  import sme_pkg::*;
#(
  parameter int XLEN = SME_XLEN_DEFAULT,
  parameter int SMAX = SME_SMAX_DEFAULT,
  localparam int IW = (SMAX > 1) ? $clog2(SMAX) : 1,
  localparam int DW = $clog2(SMAX + 1)
) (
  input  logic                           g_clk,
  input  logic                           g_rst,
  input  logic [3:0]                     smectl_d,
  input  logic                           flush,
  input  logic                           req_valid,
  output logic                           req_ready,
  output logic                           rf_ren,
  output logic [IW-1:0]                  rf_share,
  input  logic [XLEN-1:0]                rf_rs1,
  input  logic [XLEN-1:0]                rf_rs2,
  output logic                           alu_valid,
  input  logic                           alu_ready,
  output logic [SMAX-1:0][XLEN-1:0]      alu_rs1,
  output logic [SMAX-1:0][XLEN-1:0]      alu_rs2,
  output gather_state_e                  state_dbg
);

  gather_state_e            state_q, state_d;
  logic [IW-1:0]            counter_q;
  logic [DW-1:0]            d_eff_q;
  logic [DW-1:0]            d_eff_sel;
  logic                     cap_valid_q;
  logic [IW-1:0]            cap_idx_q;
  logic [SMAX-1:0][XLEN-1:0] slot_rs1_q;
  logic [SMAX-1:0][XLEN-1:0] slot_rs2_q;

  logic accept;
  logic last_fetch;
  logic alu_fire;
  logic clear_evt;

  assign accept     = (state_q == ST_IDLE) && req_valid && !flush;
  assign last_fetch = (DW'(counter_q) == (d_eff_q - DW'(1)));
  assign alu_fire   = (state_q == ST_ISSUE) && alu_ready;

`ifdef SME_GATHER_CLEAR_EN
  assign clear_evt = flush || alu_fire;
`else
  assign clear_evt = 1'b0;
`endif

  // Clamp the requested share count into 1..SMAX.
  always_comb begin
    d_eff_sel = DW'(smectl_d);
    if (smectl_d == 4'd0) begin
      d_eff_sel = DW'(1);
    end else if (int'(smectl_d) > SMAX) begin
      d_eff_sel = DW'(SMAX);
    end
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_FETCH;
      ST_FETCH: if (last_fetch) state_d = ST_LAST;
      ST_LAST:  state_d = ST_ISSUE;
      ST_ISSUE: if (alu_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      counter_q <= '0;
      d_eff_q   <= DW'(1);
    end else begin
      if (accept) begin
        d_eff_q <= d_eff_sel;
      end
      if (flush || accept || last_fetch && (state_q == ST_FETCH)) begin
        counter_q <= '0;
      end else if (state_q == ST_FETCH) begin
        counter_q <= counter_q + IW'(1);
      end
    end
  end

  // Read data arrives the cycle after rf_ren; remember which slot it belongs to.
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
    end else begin
      cap_valid_q <= (state_q == ST_FETCH) && !flush;
      cap_idx_q   <= counter_q;
    end
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      slot_rs1_q <= '0;
      slot_rs2_q <= '0;
    end else if (clear_evt) begin
      slot_rs1_q <= '0;
      slot_rs2_q <= '0;
    end else if (cap_valid_q && !flush) begin
      slot_rs1_q[cap_idx_q] <= rf_rs1;
      slot_rs2_q[cap_idx_q] <= rf_rs2;
    end
  end

  // Slots beyond the active share count never leak stale data to the ALU.
  always_comb begin
    alu_rs1 = '0;
    alu_rs2 = '0;
    for (int i = 0; i < SMAX; i++) begin
      if (i < int'(d_eff_q)) begin
        alu_rs1[i] = slot_rs1_q[i];
        alu_rs2[i] = slot_rs2_q[i];
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rf_ren    = (state_q == ST_FETCH);
  assign rf_share  = (state_q == ST_FETCH) ? counter_q : '0;
  assign alu_valid = (state_q == ST_ISSUE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sme_operand_gather.sv
// Directed bench for sme_operand_gather: share reads, clamping, stall, flush and reset.
module tb_sme_operand_gather;
  import sme_pkg::*;

  logic              g_clk = 1'b0;
  logic              g_rst = 1'b1;
  logic [3:0]        smectl_d = 4'd0;
  logic              flush = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              rf_ren;
  logic [1:0]        rf_share;
  logic [31:0]       rf_rs1 = 32'hdead_beef;
  logic [31:0]       rf_rs2 = 32'hdead_beef;
  logic              alu_valid;
  logic              alu_ready = 1'b0;
  logic [3:0][31:0]  alu_rs1;
  logic [3:0][31:0]  alu_rs2;
  gather_state_e     state_dbg;

  int total = 0;
  int bad = 0;

  sme_operand_gather #(.XLEN(32), .SMAX(4)) dut (
    .g_clk(g_clk), .g_rst(g_rst), .smectl_d(smectl_d), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .rf_ren(rf_ren), .rf_share(rf_share),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .state_dbg(state_dbg)
  );

  always #5 g_clk = ~g_clk;

  // Register-file model: data for a read appears during the following cycle only.
  logic       rd_pend = 1'b0;
  logic [1:0] rd_idx = 2'd0;
  always @(negedge g_clk) begin
    if (rd_pend) begin
      rf_rs1 = 32'h1000_0000 + {30'd0, rd_idx};
      rf_rs2 = 32'h2000_0000 + {30'd0, rd_idx};
    end else begin
      rf_rs1 = 32'hdead_beef;
      rf_rs2 = 32'hdead_beef;
    end
    rd_pend = rf_ren;
    rd_idx  = rf_share;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_slots(input string tag, input int d_exp);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_rs1_%0d", tag, i), alu_rs1[i],
            (i < d_exp) ? 32'h1000_0000 + 32'(i) : 32'h0);
      check($sformatf("%s_rs2_%0d", tag, i), alu_rs2[i],
            (i < d_exp) ? 32'h2000_0000 + 32'(i) : 32'h0);
    end
  endtask

  task automatic run_op(input int d_req, input int d_exp, input int stall);
    @(negedge g_clk);
    alu_ready = (stall == 0);
    smectl_d  = 4'(d_req);
    req_valid = 1'b1;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge g_clk);
    @(negedge g_clk);
    req_valid = 1'b0;
    smectl_d  = 4'hf;
    for (int k = 0; k < d_exp; k++) begin
      check("fetch_ren", {31'd0, rf_ren}, 32'd1);
      check("fetch_share", {30'd0, rf_share}, 32'(k));
      check("fetch_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge g_clk);
    end
    check("last_ren", {31'd0, rf_ren}, 32'd0);
    check("last_valid", {31'd0, alu_valid}, 32'd0);
    @(negedge g_clk);
    check("issue_valid", {31'd0, alu_valid}, 32'd1);
    check_slots("issue", d_exp);
    for (int s = 1; s < stall; s++) begin
      @(negedge g_clk);
      check("stall_valid", {31'd0, alu_valid}, 32'd1);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      check_slots("stall", d_exp);
    end
    alu_ready = 1'b1;
    @(negedge g_clk);
    check("done_valid", {31'd0, alu_valid}, 32'd0);
    check("done_state", 32'(state_dbg), 32'(ST_IDLE));
    check("done_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge g_clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, alu_valid}, 32'd0);
    check("rst_ren", {31'd0, rf_ren}, 32'd0);
    check("rst_share", {30'd0, rf_share}, 32'd0);
    check_slots("rst", 0);
    g_rst = 1'b0;

    run_op(2, 2, 0);
    run_op(0, 1, 0);
    run_op(9, 4, 0);
    run_op(4, 4, 5);
    run_op(1, 1, 0);

    // Flush while the second share is being read.
    @(negedge g_clk);
    alu_ready = 1'b1;
    smectl_d  = 4'd4;
    req_valid = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    req_valid = 1'b0;
    check("flush_share0", {30'd0, rf_share}, 32'd0);
    @(negedge g_clk);
    check("flush_share1", {30'd0, rf_share}, 32'd1);
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    check("flush_ren", {31'd0, rf_ren}, 32'd0);
    check("flush_req_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (alu_valid) seen++;
      @(negedge g_clk);
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // Reset raised mid-ISSUE.
    alu_ready = 1'b0;
    smectl_d  = 4'd4;
    req_valid = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    req_valid = 1'b0;
    repeat (5) @(negedge g_clk);
    check("rstmid_issue", {31'd0, alu_valid}, 32'd1);
    #2 g_rst = 1'b1;
    #1;
    check("rstmid_valid", {31'd0, alu_valid}, 32'd0);
    check("rstmid_rs1_0", alu_rs1[0], 32'd0);
    check("rstmid_rs2_3", alu_rs2[3], 32'd0);
    check("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge g_clk);
    g_rst = 1'b0;
    alu_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (alu_valid) seen++;
      @(negedge g_clk);
    end
    check("rstmid_no_valid", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
